// File: rtl/sad_min_locator_if.sv
// sad_min_locator_if: SAD stream input and best-match result handshake bundle
interface sad_min_locator_if #(parameter int SAD_W = 10, LANES = 8, COLS = 640, ROWS = 480);
  logic start;
  logic in_valid;
  logic in_ready;
  logic [LANES*SAD_W-1:0] in_sad;
  logic out_valid;
  logic out_ready;
  logic [SAD_W-1:0] best_sad;
  logic [$clog2(ROWS)-1:0] best_row;
  logic [$clog2(COLS)-1:0] best_col;
  logic busy;
  modport master (output start, in_valid, in_sad, out_ready,
                  input in_ready, out_valid, best_sad, best_row, best_col, busy);
  modport slave (input start, in_valid, in_sad, out_ready,
                 output in_ready, out_valid, best_sad, best_row, best_col, busy);
endinterface

// File: rtl/sad_min_locator.sv
// sad_min_locator: running argmin over a raster SAD stream with valid/ready result
module sad_min_locator #(parameter int SAD_W = 10, LANES = 8, COLS = 640, ROWS = 480) (
  input logic clk,
  input logic rst,
  sad_min_locator_if.slave bus
);
  localparam int BPR = COLS / LANES;
  localparam int BW = BPR > 1 ? $clog2(BPR) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat_cnt;
  logic [RW-1:0] row_cnt;
  logic flush_cnt;
  logic accept, last_beat, launch;
  logic [SAD_W-1:0] red_min;
  logic [LW-1:0] red_lane;
  logic s1_valid, s1_first;
  logic [SAD_W-1:0] s1_min;
  logic [LW-1:0] s1_lane;
  logic [BW-1:0] s1_beat;
  logic [RW-1:0] s1_row;
  logic [SAD_W-1:0] best_sad;
  logic [RW-1:0] best_row;
  logic [CW-1:0] best_col;
  assign accept = state == RUN && bus.in_valid;
  assign launch = state == IDLE && bus.start;
  assign last_beat = row_cnt == RW'(ROWS - 1) && beat_cnt == BW'(BPR - 1);
  assign bus.best_sad = best_sad;
  assign bus.best_row = best_row;
  assign bus.best_col = best_col;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and handshake outputs; FLUSH holds two cycles so S1 and S2 drain
  always_comb begin
    state_nx = state;
    bus.in_ready = state == RUN;
    bus.out_valid = state == DONE;
    bus.busy = state == RUN || state == FLUSH;
    state_nx = launch ? RUN :
               accept && last_beat ? FLUSH :
               state == FLUSH && flush_cnt ? DONE :
               state == DONE && bus.out_ready ? IDLE : state;
  end
  // raster position of the next accepted beat
  always_ff @(posedge clk)
    if (rst || launch) begin
      beat_cnt <= '0;
      row_cnt <= '0;
      flush_cnt <= 1'b0;
    end else begin
      flush_cnt <= state == FLUSH ? ~flush_cnt : 1'b0;
      if (accept) begin
        beat_cnt <= beat_cnt == BW'(BPR - 1) ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == BW'(BPR - 1)) row_cnt <= last_beat ? '0 : row_cnt + 1'b1;
      end
    end
  // lane reduction; strict compare keeps the lowest lane among equal minima
  always_comb begin
    red_min = bus.in_sad[SAD_W-1:0];
    red_lane = '0;
    for (int k = 1; k < LANES; k++)
      if (bus.in_sad[k*SAD_W +: SAD_W] < red_min) begin
        red_min = bus.in_sad[k*SAD_W +: SAD_W];
        red_lane = LW'(k);
      end
  end
  // S1: register beat minimum with its raster tags
  always_ff @(posedge clk)
    if (rst) s1_valid <= 1'b0;
    else begin
      s1_valid <= accept;
      s1_first <= row_cnt == '0 && beat_cnt == '0;
      s1_min <= red_min;
      s1_lane <= red_lane;
      s1_beat <= beat_cnt;
      s1_row <= row_cnt;
    end
  // S2: running minimum; first beat loads unconditionally, later beats need strictly less
  always_ff @(posedge clk)
    if (rst || launch) begin
      best_sad <= '1;
      best_row <= '0;
      best_col <= '0;
    end else if (s1_valid && (s1_first || s1_min < best_sad)) begin
      best_sad <= s1_min;
      best_row <= s1_row;
      best_col <= CW'(s1_beat) * CW'(LANES) + CW'(s1_lane);
    end
endmodule

// File: tb/tb_sad_min_locator.sv
// tb_sad_min_locator: directed and random searches checked against a scoreboard argmin
module tb_sad_min_locator;
  localparam int SAD_W = 10, LANES = 8, COLS = 16, ROWS = 2, BPR = COLS / LANES;
  typedef struct {int sad; int row; int col;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [SAD_W-1:0] win [ROWS][COLS];
  res_t sb [$];
  always #5 clk = ~clk;
  sad_min_locator_if #(.SAD_W(SAD_W), .LANES(LANES), .COLS(COLS), .ROWS(ROWS)) bus ();
  sad_min_locator #(.SAD_W(SAD_W), .LANES(LANES), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        win[r][c] = base < 0 ? SAD_W'($urandom_range(1023)) : SAD_W'(base);
  endtask

  task automatic push_exp();
    res_t e;
    e.sad = int'(win[0][0]); e.row = 0; e.col = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (int'(win[r][c]) < e.sad) begin
          e.sad = int'(win[r][c]); e.row = r; e.col = c;
        end
    sb.push_back(e);
  endtask

  task automatic drive_beat(input int beat);
    for (int k = 0; k < LANES; k++)
      bus.in_sad[k*SAD_W +: SAD_W] = win[beat / BPR][(beat % BPR) * LANES + k];
  endtask

  task automatic run_search(input string tag, input int gap_pct, input int start_beat, input bit hold);
    int beat = 0, n = 0, lat = 1;
    bit acc;
    res_t e;
    push_exp();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_in_ready_run"}, bus.in_ready, 1);
    chk({tag, "_busy_run"}, bus.busy, 1);
    while (beat < ROWS * BPR && n < 2000) begin
      bus.in_valid = $urandom_range(99) >= gap_pct;
      drive_beat(beat);
      bus.start = beat == start_beat;
      acc = bus.in_valid && bus.in_ready;
      tick();
      n++;
      bus.start = 1'b0;
      if (acc) beat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_beats"}, beat, ROWS * BPR);
    chk({tag, "_flush_in_ready"}, bus.in_ready, 0);
    chk({tag, "_flush_busy"}, bus.busy, 1);
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    e = sb.pop_front();
    if (hold) begin
      bus.start = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        bus.start = 1'b0;
        chk({tag, "_hold_valid"}, bus.out_valid, 1);
        chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
        chk({tag, "_hold_sad"}, bus.best_sad, e.sad);
      end
    end
    chk({tag, "_best_sad"}, bus.best_sad, e.sad);
    chk({tag, "_best_row"}, bus.best_row, e.row);
    chk({tag, "_best_col"}, bus.best_col, e.col);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_done_valid"}, bus.out_valid, 0);
    chk({tag, "_done_busy"}, bus.busy, 0);
    tick();
    chk({tag, "_idle_in_ready"}, bus.in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sad = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_best_sad", bus.best_sad, 1023);
    chk("rst_best_row", bus.best_row, 0);
    chk("rst_best_col", bus.best_col, 0);
    fill(100);
    win[1][13] = 7;
    run_search("single_min", 0, -1, 1'b0);
    fill(9);
    win[0][3] = 5;
    win[1][0] = 5;
    run_search("tie", 0, -1, 1'b0);
    fill(1023);
    run_search("all_ones", 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fill(-1);
      run_search("random", 50, -1, i == 1);
    end
    fill(50);
    win[0][5] = 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.in_valid = 1'b1;
      drive_beat(b);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_best_sad", bus.best_sad, 1023);
    chk("midrst_best_col", bus.best_col, 0);
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_result", bus.out_valid, 0);
    end
    fill(50);
    win[0][0] = 2;
    run_search("after_rst", 0, -1, 1'b0);
    fill(-1);
    run_search("start_ignored", 30, 1, 1'b1);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
